// File: rtl/bloonstd1_soc_keys_pio.sv
// Avalon-MM input PIO: synchronises and debounces push-button/switch inputs,
// latches edge events into a write-1-to-clear register and raises a level IRQ.
module bloonstd1_soc_keys_pio #(
    parameter int unsigned       WIDTH           = 4,
    parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd0,
    parameter logic [1:0]        EDGE_TYPE       = 2'd1,
    parameter logic [WIDTH-1:0]  IN_RESET_VALUE  = WIDTH'(4'hF)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic             read_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned DEB_D = int'(DEBOUNCE_CYCLES);
    localparam int unsigned CNT_W = (DEB_D == 0) ? 1 : $clog2(DEB_D + 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_ANY  = 2'd2;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_capture_d;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      readdata_d;
    logic             irq_d;
    logic             wr;

    // read_n carries no side effects here; writedata is only partly decoded
    logic unused;
    assign unused = &{1'b0, read_n, writedata};

    // Two-flop synchroniser on the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET_VALUE;
            sync2 <= IN_RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    if (DEB_D == 0) begin : g_bypass
        always_comb begin
            deb_d = sync2;
        end
    end else begin : g_debounce
        // Counter saturates at D-1 by construction: reaching it commits the new value
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_D - 1);

        logic [CNT_W-1:0] cnt   [WIDTH];
        logic [CNT_W-1:0] cnt_d [WIDTH];

        always_comb begin
            deb_d = deb;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_d[i] = '0;
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb_d[i] = sync2[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt[i] + CNT_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                cnt <= cnt_d;
            end
        end
    end

    // Edge event selection; deb_prev resets to the same value as deb so no event follows reset
    always_comb begin
        evt = '0;
        case (EDGE_TYPE)
            EDGE_RISE: evt = deb & ~deb_prev;
            EDGE_FALL: evt = ~deb & deb_prev;
            EDGE_ANY:  evt = deb ^ deb_prev;
            default:   evt = '0;
        endcase
    end

    // Bus decode, register next-state and read mux
    always_comb begin
        wr             = chipselect && !write_n;
        irq_mask_d     = irq_mask;
        edge_clr       = '0;
        readdata_d     = '0;

        if (wr && (address == ADDR_MASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr && (address == ADDR_EDGE)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        // A new event on a bit being cleared in the same cycle keeps the bit set
        edge_capture_d = (edge_capture & ~edge_clr) | evt;

        case (address)
            ADDR_DATA: readdata_d = 32'(deb);
            ADDR_MASK: readdata_d = 32'(irq_mask);
            ADDR_EDGE: readdata_d = 32'(edge_capture);
            default:   readdata_d = '0;
        endcase

        irq_d = |(edge_capture & irq_mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb          <= IN_RESET_VALUE;
            deb_prev     <= IN_RESET_VALUE;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            deb          <= deb_d;
            deb_prev     <= deb;
            irq_mask     <= irq_mask_d;
            edge_capture <= edge_capture_d;
            readdata     <= readdata_d;
            irq          <= irq_d;
        end
    end

endmodule

// File: tb/tb_bloonstd1_soc_keys_pio.sv
// Directed bench for the keys PIO: one falling-edge instance and one any-edge
// instance, both debounced over 4 cycles and sharing the bus.
module tb_bloonstd1_soc_keys_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bloonstd1_soc_keys_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(16'd4), .EDGE_TYPE(2'd1), .IN_RESET_VALUE(4'hF)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in_a), .readdata(rd_a), .irq(irq_a)
    );

    bloonstd1_soc_keys_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(16'd4), .EDGE_TYPE(2'd2), .IN_RESET_VALUE(4'hF)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in_b), .readdata(rd_b), .irq(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input logic [1:0] a);
        address = a;
        read_n  = 1'b0;
        @(negedge clk);
        read_n  = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        read_n     = 1'b1;
        in_a       = 4'hF;
        in_b       = 4'hF;

        // Reset state
        wait_neg(2);
        check("reset_readdata", rd_a, 32'h0);
        check("reset_irq", 32'(irq_a), 32'h0);
        reset_n = 1'b1;
        do_read(2'd0);
        check("idle_addr0", rd_a, 32'h0000000F);
        do_read(2'd3);
        check("idle_addr3", rd_a, 32'h0);
        check("idle_irq", 32'(irq_a), 32'h0);
        do_read(2'd1);
        check("reserved_addr1", rd_a, 32'h0);

        // 3-cycle glitch is filtered
        in_a = 4'hE;
        wait_neg(3);
        in_a = 4'hF;
        wait_neg(10);
        do_read(2'd0);
        check("glitch_addr0", rd_a, 32'h0000000F);
        do_read(2'd3);
        check("glitch_addr3", rd_a, 32'h0);

        // Sustained low passes the debouncer and is captured as a falling edge
        in_a = 4'hE;
        wait_neg(10);
        do_read(2'd0);
        check("hold_addr0", rd_a, 32'h0000000E);
        do_read(2'd3);
        check("hold_addr3", rd_a, 32'h00000001);
        check("hold_irq_unmasked", 32'(irq_a), 32'h0);

        // Rising edge not captured in falling mode; then clear and unmask bit0
        in_a = 4'hF;
        wait_neg(10);
        do_read(2'd3);
        check("rise_ignored_addr3", rd_a, 32'h00000001);
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check("w1c_addr3", rd_a, 32'h0);
        do_write(2'd2, 32'h1);
        do_read(2'd2);
        check("mask_readback", rd_a, 32'h00000001);
        check("mask_no_irq", 32'(irq_a), 32'h0);

        // IRQ latency k+3+D: low after edge k+6, high after edge k+7
        in_a = 4'hE;
        wait_neg(7);
        check("irq_before_latency", 32'(irq_a), 32'h0);
        wait_neg(1);
        check("irq_at_latency", 32'(irq_a), 32'h1);
        do_write(2'd3, 32'h1);
        check("irq_after_clear_1st", 32'(irq_a), 32'h1);
        wait_neg(1);
        check("irq_after_clear_2nd", 32'(irq_a), 32'h0);

        // Clear write coincident with a fresh capture: set wins
        in_a = 4'hF;
        wait_neg(10);
        in_a = 4'hE;
        wait_neg(6);
        do_write(2'd3, 32'h1);
        check("collide_irq_pre", 32'(irq_a), 32'h0);
        wait_neg(1);
        check("collide_irq_set", 32'(irq_a), 32'h1);
        do_read(2'd3);
        check("collide_addr3", rd_a, 32'h00000001);
        check("collide_irq_hold", 32'(irq_a), 32'h1);

        do_write(2'd3, 32'hF);
        do_write(2'd2, 32'h0);
        wait_neg(1);
        check("cleanup_irq", 32'(irq_a), 32'h0);

        // Any-edge instance: one capture per transition, masked irq stays low
        in_b = 4'hB;
        wait_neg(10);
        do_read(2'd3);
        check("any_fall_addr3", rd_b, 32'h00000004);
        check("any_fall_irq", 32'(irq_b), 32'h0);
        do_write(2'd3, 32'h4);
        do_read(2'd3);
        check("any_clear_addr3", rd_b, 32'h0);
        in_b = 4'hF;
        wait_neg(10);
        do_read(2'd3);
        check("any_rise_addr3", rd_b, 32'h00000004);
        check("any_rise_irq", 32'(irq_b), 32'h0);
        check("any_other_dut_addr3", rd_a, 32'h0);

        // Reset mid-debounce (bit1 counter at 2)
        address = 2'd0;
        in_a = 4'hC;
        wait_neg(4);
        check("pre_reset_addr0", rd_a, 32'h0000000E);
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", rd_a, 32'h0);
        check("async_reset_irq", 32'(irq_a), 32'h0);
        in_a = 4'hF;
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(10);
        do_read(2'd3);
        check("post_reset_addr3", rd_a, 32'h0);
        do_read(2'd0);
        check("post_reset_addr0", rd_a, 32'h0000000F);
        check("post_reset_irq", 32'(irq_a), 32'h0);

        // Input already low at reset release yields one falling event
        reset_n = 1'b0;
        in_a = 4'hE;
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(10);
        do_read(2'd3);
        check("low_at_release_addr3", rd_a, 32'h00000001);
        do_read(2'd0);
        check("low_at_release_addr0", rd_a, 32'h0000000E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
